pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
// Front-end PC register and instruction-fetch controller, downstream of the EX-stage branch controller.
// Consumes its pc_sel redirect plus the branch/jump target, and issues one-outstanding fetches to imem over valid/ready.
// Delivers instructions to IF/ID through a 2-entry (main + skid) buffer that honours hazard stalls.
// Drives the IF/ID and ID/EX flush for taken branches and jumps.
// PARAMETERS
// RESET_PC  32'h0000_0000  first fetch address after reset
// PORTS
// clk            in   1   core clock
// reset_n        in   1   asynchronous, active-low reset
// pc_sel         in   1   redirect request from branch controller (taken branch or jump)
// target_addr    in   32  redirect target, valid when pc_sel=1
// stall          in   1   hazard unit: IF/ID must hold its current instruction
// if_req_valid   out  1   fetch request valid
// if_req_addr    out  32  fetch address (word aligned)
// if_req_ready   in   1   imem accepts request
// if_rsp_valid   in   1   imem read data valid (>=1 cycle after accept)
// if_rsp_data    in   32  instruction word
// inst_valid     out  1   IF/ID holds a valid instruction
// inst           out  32  instruction to decode
// inst_pc        out  32  PC of inst
// flush_if_id    out  1   squash IF/ID
// flush_id_ex    out  1   squash ID/EX
// BEHAVIOUR
// Reset: pc=RESET_PC, state=REQ, inst_valid=0, skid empty, inst=0, inst_pc=0, if_req_valid=0, flush_*=0.
// Registers: pc (next fetch address), inflight_pc (address of the outstanding request).
// FSM states:
//  REQ:  if_req_valid = ~pc_sel & ~skid_valid; if_req_addr = pc.
//        On accept (valid&ready): inflight_pc<=pc; pc<=pc+4 (mod 2^32, so 0xFFFF_FFFC -> 0); go WAIT.
//  WAIT: if_req_valid=0. On if_rsp_valid: deliver {if_rsp_data, inflight_pc} to the buffer; go REQ.
//  DROP: if_req_valid=0. On if_rsp_valid: discard the data; go REQ.
// Redirect (pc_sel=1), which has priority over stall and all else:
//  - pc <= {target_addr[31:2],2'b00}.
//  - flush_if_id = flush_id_ex = pc_sel (combinational, same cycle).
//  - Next cycle: inst_valid=0 and skid emptied.
//  - REQ -> stay REQ. No request is issued in the redirect cycle.
//  - WAIT without rsp -> DROP. WAIT with rsp in the same cycle -> discard rsp, go REQ.
//  - DROP stays DROP; pc is updated again (last redirect wins).
// Buffer:
//  - Main register drives inst/inst_pc/inst_valid.
//  - If ~stall | ~inst_valid: main <= skid if skid valid, else the delivered rsp, else empty.
//  - If stall & inst_valid: main holds; a delivered rsp is written to skid.
//  - Skid never overflows: no request issues while skid is valid, and at most one fetch is outstanding.
// Latency: request accepted in cycle N, rsp in N+k -> inst_valid in N+k+1 (no stall). Zero-bubble issue: REQ is re-entered in the rsp cycle.
// Reset mid-operation: all state cleared asynchronously. A late imem rsp that arrives in REQ is ignored; imem must not respond after reset.
// if_rsp_valid arriving in REQ state is ignored (protocol violation; assertion in bench).
// TESTING
// 1) Release reset, ready=1, rsp 1 cycle later -> requests 0x0,0x4,0x8; inst_pc follows, each one cycle after its rsp.
// 2) pc_sel=1, target=0x100 while in WAIT; rsp arrives next cycle -> rsp dropped, flush_* high 1 cycle, next req addr 0x100.
// 3) pc_sel=1, target=0x203, in the same cycle as rsp in WAIT -> rsp discarded, next req addr 0x200, inst_valid=0.
// 4) stall=1 with inst_valid=1, rsp arrives -> goes to skid, no new req; drop stall -> skid inst appears next cycle, req resumes.
// 5) target=0xFFFF_FFFC -> fetch 0xFFFF_FFFC then 0x0000_0000.
// 6) reset_n low mid-WAIT -> all outputs 0 immediately; after release, first req addr = RESET_PC.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// PC register and one-outstanding instruction-fetch controller with a main+skid
// IF/ID buffer; applies branch-controller redirects and generates pipeline flushes.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pc_sel,
    input  logic [31:0] target_addr,
    input  logic        stall,
    output logic        if_req_valid,
    output logic [31:0] if_req_addr,
    input  logic        if_req_ready,
    input  logic        if_rsp_valid,
    input  logic [31:0] if_rsp_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        flush_if_id,
    output logic        flush_id_ex
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_inflight_pc;
    logic              r_inst_valid;
    logic [XLEN-1:0]   r_inst;
    logic [XLEN-1:0]   r_inst_pc;
    logic              r_skid_valid;
    logic [XLEN-1:0]   r_skid_inst;
    logic [XLEN-1:0]   r_skid_pc;

    logic              w_req_valid;
    logic              w_accept;
    logic              w_deliver;
    logic              w_flush;
    logic [XLEN-1:0]   w_target;

    // Redirect target forced to word alignment.
    assign w_target = target_addr & ~XLEN'(3);

    // Next-state and handshake decode; reset gates the combinational outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_req_valid = 1'b0;
        w_deliver   = 1'b0;
        w_flush     = reset_n & pc_sel;
        case (r_state)
            S_REQ: begin
                w_req_valid = reset_n & ~pc_sel & ~r_skid_valid;
                if (w_req_valid && if_req_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (if_rsp_valid) begin
                    w_deliver   = ~pc_sel;
                    w_state_nxt = S_REQ;
                end else if (pc_sel) begin
                    w_state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (if_rsp_valid) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    assign w_accept     = w_req_valid & if_req_ready;
    assign if_req_valid = w_req_valid;
    assign if_req_addr  = r_pc;
    assign flush_if_id  = w_flush;
    assign flush_id_ex  = w_flush;
    assign inst_valid   = r_inst_valid;
    assign inst         = r_inst;
    assign inst_pc      = r_inst_pc;

    // FSM state, fetch PC and address of the outstanding request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_REQ;
            r_pc          <= RESET_PC;
            r_inflight_pc <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (pc_sel) begin
                r_pc <= w_target;
            end else if (w_accept) begin
                r_pc          <= r_pc + XLEN'(4);
                r_inflight_pc <= r_pc;
            end
        end
    end

    // IF/ID main register plus skid slot that catches a response landing during a stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_inst_valid <= 1'b0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_skid_valid <= 1'b0;
            r_skid_inst  <= '0;
            r_skid_pc    <= '0;
        end else if (pc_sel) begin
            r_inst_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!stall || !r_inst_valid) begin
            if (r_skid_valid) begin
                r_inst_valid <= 1'b1;
                r_inst       <= r_skid_inst;
                r_inst_pc    <= r_skid_pc;
                r_skid_valid <= 1'b0;
            end else if (w_deliver) begin
                r_inst_valid <= 1'b1;
                r_inst       <= if_rsp_data;
                r_inst_pc    <= r_inflight_pc;
            end else begin
                r_inst_valid <= 1'b0;
            end
        end else if (w_deliver) begin
            r_skid_valid <= 1'b1;
            r_skid_inst  <= if_rsp_data;
            r_skid_pc    <= r_inflight_pc;
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: an imem responder with programmable latency,
// expected fetch addresses and instructions queued by the stimulus, checked by a monitor.
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        reset_n;
    logic        pc_sel;
    logic [31:0] target_addr;
    logic        stall;
    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        if_req_ready;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        flush_if_id;
    logic        flush_id_ex;

    int          errors = 0;
    int          checks = 0;
    int          rsp_lat;
    int          epoch;

    logic [31:0] exp_req[$];
    logic [63:0] exp_inst[$];

    pc_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pc_sel       (pc_sel),
        .target_addr  (target_addr),
        .stall        (stall),
        .if_req_valid (if_req_valid),
        .if_req_addr  (if_req_addr),
        .if_req_ready (if_req_ready),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_data  (if_rsp_data),
        .inst_valid   (inst_valid),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_fetch(input logic [31:0] a);
        exp_req.push_back(a);
        exp_inst.push_back({imem_word(a), a});
    endtask

    // imem: answers each accepted request after rsp_lat cycles unless a reset intervened.
    initial begin
        logic [31:0] a;
        int          e;
        int          l;
        if_rsp_valid = 1'b0;
        if_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (reset_n && if_req_valid && if_req_ready) begin
                a = if_req_addr;
                e = epoch;
                l = rsp_lat;
                for (int k = 0; k < l; k++) begin
                    @(posedge clk);
                    #1;
                end
                if (e == epoch) begin
                    if_rsp_valid = 1'b1;
                    if_rsp_data  = imem_word(a);
                    @(posedge clk);
                    #1;
                    if_rsp_valid = 1'b0;
                end
            end
        end
    end

    // Monitor: fetch addresses, newly presented instructions, held instructions, flushes.
    initial begin
        logic        prev_iv;
        logic        prev_stall;
        logic [63:0] prev_ip;
        logic [31:0] e_req;
        logic [63:0] e_inst;
        prev_iv    = 1'b0;
        prev_stall = 1'b0;
        prev_ip    = '0;
        forever begin
            @(negedge clk);
            if (if_req_valid && if_req_ready) begin
                checks++;
                if (exp_req.size() == 0) begin
                    errors++;
                    $display("FAIL req_unexpected: got addr 0x%08h expected no request", if_req_addr);
                end else begin
                    e_req = exp_req.pop_front();
                    if (if_req_addr !== e_req) begin
                        errors++;
                        $display("FAIL req_addr: got 0x%08h expected 0x%08h at %0t", if_req_addr, e_req, $time);
                    end
                end
            end
            if (inst_valid && prev_iv && prev_stall) begin
                checks++;
                if ({inst, inst_pc} !== prev_ip) begin
                    errors++;
                    $display("FAIL inst_hold: got %h/%h expected %h/%h at %0t", inst, inst_pc, prev_ip[63:32], prev_ip[31:0], $time);
                end
            end else if (inst_valid) begin
                checks++;
                if (exp_inst.size() == 0) begin
                    errors++;
                    $display("FAIL inst_unexpected: got %h/%h expected no instruction", inst, inst_pc);
                end else begin
                    e_inst = exp_inst.pop_front();
                    if ({inst, inst_pc} !== e_inst) begin
                        errors++;
                        $display("FAIL inst: got %h/%h expected %h/%h at %0t", inst, inst_pc, e_inst[63:32], e_inst[31:0], $time);
                    end
                end
            end
            if (pc_sel || flush_if_id || flush_id_ex) begin
                checks++;
                if (flush_if_id !== pc_sel || flush_id_ex !== pc_sel) begin
                    errors++;
                    $display("FAIL flush: got %b%b expected %b%b at %0t", flush_if_id, flush_id_ex, pc_sel, pc_sel, $time);
                end
            end
            prev_iv    = inst_valid;
            prev_stall = stall;
            prev_ip    = {inst, inst_pc};
        end
    end

    initial begin
        #5000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n      = 1'b1;
        pc_sel       = 1'b0;
        target_addr  = '0;
        stall        = 1'b0;
        if_req_ready = 1'b1;
        rsp_lat      = 1;
        epoch        = 0;
        #1 reset_n   = 1'b0;
        #2;
        chk("rst_req_valid", 32'(if_req_valid), 32'd0);
        chk("rst_req_addr", if_req_addr, 32'h0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_flush", 32'({flush_if_id, flush_id_ex}), 32'd0);

        // Sequential fetch 0x0, 0x4, 0x8 with 1-cycle imem latency.
        push_fetch(32'h0);
        push_fetch(32'h4);
        push_fetch(32'h8);
        cyc(2);
        reset_n = 1'b1;
        cyc(6);
        if_req_ready = 1'b0;

        // Redirect while waiting; the late response must be dropped.
        cyc(1);
        if_req_ready = 1'b1;
        rsp_lat = 2;
        exp_req.push_back(32'hC);
        cyc(1);
        pc_sel = 1'b1;
        target_addr = 32'h100;
        cyc(1);
        pc_sel = 1'b0;
        rsp_lat = 1;
        chk("drop_inst_valid", 32'(inst_valid), 32'd0);
        push_fetch(32'h100);
        exp_req.push_back(32'h104);

        // Redirect coincident with the response; misaligned target.
        cyc(4);
        pc_sel = 1'b1;
        target_addr = 32'h203;
        cyc(1);
        pc_sel = 1'b0;
        chk("redir_inst_valid", 32'(inst_valid), 32'd0);
        push_fetch(32'h200);

        // Stall: response parks in the skid and blocks further requests.
        push_fetch(32'h204);
        push_fetch(32'h208);
        cyc(2);
        stall = 1'b1;
        cyc(2);
        chk("skid_no_req", 32'(if_req_valid), 32'd0);
        chk("stall_inst_pc", inst_pc, 32'h200);
        chk("stall_inst_valid", 32'(inst_valid), 32'd1);
        cyc(1);
        stall = 1'b0;
        cyc(2);
        if_req_ready = 1'b0;

        // PC wrap from the top of the address space.
        cyc(1);
        pc_sel = 1'b1;
        target_addr = 32'hFFFF_FFFC;
        cyc(1);
        pc_sel = 1'b0;
        if_req_ready = 1'b1;
        chk("wrap_inst_valid", 32'(inst_valid), 32'd0);
        push_fetch(32'hFFFF_FFFC);
        push_fetch(32'h0);
        cyc(3);
        if_req_ready = 1'b0;
        stall = 1'b1;

        // Asynchronous reset while a fetch is outstanding.
        cyc(2);
        if_req_ready = 1'b1;
        rsp_lat = 3;
        exp_req.push_back(32'h4);
        cyc(1);
        chk("pre_rst_inst_valid", 32'(inst_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        epoch++;
        #1;
        chk("arst_req_valid", 32'(if_req_valid), 32'd0);
        chk("arst_req_addr", if_req_addr, 32'h0);
        chk("arst_inst_valid", 32'(inst_valid), 32'd0);
        chk("arst_inst", inst, 32'h0);
        chk("arst_inst_pc", inst_pc, 32'h0);
        rsp_lat = 1;
        push_fetch(32'h0);
        cyc(3);
        reset_n = 1'b1;
        stall = 1'b0;
        cyc(1);
        if_req_ready = 1'b0;
        cyc(4);

        chk("req_queue_left", 32'(exp_req.size()), 32'd0);
        chk("inst_queue_left", 32'(exp_inst.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
